// File: rtl/seq_mant_mul.sv
// Sequential 24x24 mantissa multiplier: one shift-add per cycle over 24 cycles.
// Optional SEQ_MUL_ZERO_BYPASS_EN: zero operands skip RUN and go straight to DONE.
module seq_mant_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] p,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [23:0] a_q, a_d;
  logic [24:0] acc_hi_q, acc_hi_d;
  logic [23:0] mq_q, mq_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [24:0] add_sum;
  logic [24:0] sum;
  logic        unused_acc_msb;

  // The only adder; its carry lands in bit 24 and is shifted back into acc_hi[23].
  assign add_sum = {1'b0, acc_hi_q[23:0]} + {1'b0, a_q};

  // acc_hi[24] is always zero after the shift, so it never feeds anything.
  assign unused_acc_msb = acc_hi_q[24];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    sum      = mq_q[0] ? add_sum : {1'b0, acc_hi_q[23:0]};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          acc_hi_d = '0;
          mq_d     = b;
          cnt_d    = '0;
          state_d  = S_RUN;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
          if (a == 24'd0 || b == 24'd0) begin
            mq_d    = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        {acc_hi_d, mq_d} = {sum, mq_q} >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      acc_hi_q <= '0;
      mq_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign p         = out_valid ? {acc_hi_q[23:0], mq_q} : 48'd0;

endmodule

// File: tb/tb_seq_mant_mul.sv
// Scoreboard bench for seq_mant_mul: driver pushes a*b and due cycle, monitor pops on handshake.
module tb_seq_mant_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] p;
  logic        busy;

`ifdef SEQ_MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [47:0] p;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 1;

  seq_mant_mul dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain arithmetic product; latency 25 cycles, or 1 for a bypassed zero.
  function automatic exp_t model(input logic [23:0] x, input logic [23:0] y, input int t);
    exp_t e;
    e.p   = 48'(x) * 48'(y);
    e.due = t + ((BYP && (x == 24'd0 || y == 24'd0)) ? 1 : 25);
    return e;
  endfunction

  task automatic drive_ready();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom);
    endcase
  endtask

  // One cycle of background driving: junk operands whenever the block cannot accept.
  task automatic tick();
    @(negedge clk);
    drive_ready();
    if (in_ready) in_valid = 1'b0;
    else begin
      in_valid = 1'($urandom);
      a = 24'($urandom);
      b = 24'($urandom);
    end
  endtask

  task automatic issue(input logic [23:0] va, input logic [23:0] vb, output int t);
    int g;
    g = 0;
    t = -1;
    while (t < 0) begin
      @(negedge clk);
      drive_ready();
      if (in_ready) begin
        in_valid = 1'b1;
        a = va;
        b = vb;
        t = cyc;
        sb.push_back(model(va, vb, cyc));
      end else begin
        in_valid = 1'($urandom);
        a = 24'($urandom);
        b = 24'($urandom);
        g++;
        if (g > 300) begin
          n_vec++; n_err++;
          $display("FAIL issue_timeout: in_ready=0 after %0d cycles, want 1", g);
          t = cyc;
        end
      end
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    ready_mode = (ready_mode == 0) ? 1 : ready_mode;
    while ((sb.size() != 0 || !in_ready) && g < 500) begin
      tick();
      g++;
    end
    if (g >= 500) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
    end
  endtask

  // Monitor: compares the first DONE cycle against the scoreboard head, then checks hold.
  initial begin
    bit          inflight;
    logic [47:0] held;
    exp_t        e;
    inflight = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        inflight = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!inflight) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: p=%h appeared, want no result pending", p);
          end else begin
            e = sb[0];
            check("latency", 64'(cyc), 64'(e.due));
            check("product", 64'(p), 64'(e.p));
          end
          held = p;
          inflight = 1'b1;
        end else begin
          check("p_hold", 64'(p), 64'(held));
        end
        check("done_flags", {62'd0, busy, in_ready}, 64'd0);
        if (out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          inflight = 1'b0;
        end
      end else begin
        check("p_zero_not_done", 64'(p), 64'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2;
    logic [23:0] x, y;
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 24'h123456;
    b = 24'h654321;
    out_ready = 1'b0;

    // Reset with in_valid high must not accept anything.
    repeat (3) @(negedge clk);
    #1;
    check("rst_flags", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
    check("rst_p", 64'(p), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_idle", {62'd0, in_ready, busy}, 64'd2);

    ready_mode = 1;
    issue(24'h800000, 24'h800000, t);  drain();
    issue(24'hFFFFFF, 24'hFFFFFF, t);  drain();
    issue(24'h000000, 24'hABCDEF, t);  drain();
    issue(24'hABCDEF, 24'h000000, t);  drain();
    issue(24'h000001, 24'hFFFFFF, t);  drain();

    // Stall: result held for 10 cycles, new in_valid ignored.
    ready_mode = 0;
    issue(24'hC00000, 24'hA00000, t);
    t2 = 0;
    while (!out_valid && t2 < 100) begin tick(); t2++; end
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = 1'b1;
      a = 24'h111111 + 24'(i);
      b = 24'h222222;
      #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    ready_mode = 1;
    tick();
    tick();
    #1;
    check("stall_release_idle", 64'(in_ready), 64'd1);
    drain();

    // Back-to-back: 26-cycle period.
    x = 24'($urandom) | 24'd1;
    y = 24'($urandom) | 24'd1;
    issue(x, y, t);
    issue(y, x, t2);
    check("b2b_period", 64'(t2 - t), 64'd26);
    drain();

    // Reset in the middle of RUN (cnt==10) discards the operation.
    issue(24'hDEADBE, 24'h7FFFFF, t);
    repeat (11) tick();
    rst_n = 1'b0;
    in_valid = 1'b1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrun_rst_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
    check("midrun_rst_p", 64'(p), 64'd0);
    issue(24'h000003, 24'h000005, t);
    drain();

    // Randomized traffic with random consumer backpressure.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      x = 24'($urandom);
      y = 24'($urandom);
      if (i % 8 == 3) x = 24'd0;
      if (i % 8 == 6) y = 24'd0;
      if (i % 8 == 1) x = 24'hFFFFFF;
      issue(x, y, t);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
